// File: rtl/vlog_fsm_pkg.sv
// rtl/vlog_fsm_pkg.sv - shared state encodings and default sizes for the request controller
package vlog_fsm_pkg;

    typedef enum logic [1:0] {
        REQ_IDLE    = 2'd0,
        REQ_ACTIVE  = 2'd1,
        REQ_RELEASE = 2'd2
    } req_state_t;

    localparam int DEF_LEN_W = 4;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_PTR_W = 2;

endpackage : vlog_fsm_pkg

// File: rtl/vlog_fsm_job_fifo.sv
// rtl/vlog_fsm_job_fifo.sv - synchronous job-length FIFO with full/empty/occupancy
module vlog_fsm_job_fifo
    import vlog_fsm_pkg::*;
#(
    parameter int W     = DEF_LEN_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR_W = DEF_PTR_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (PTR_W+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : vlog_fsm_job_fifo

// File: rtl/vlog_fsm_req_ctrl.sv
// rtl/vlog_fsm_req_ctrl.sv - per-requester job queue and level-request FSM for the grant arbiter
module vlog_fsm_req_ctrl
    import vlog_fsm_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int PTR_W = DEF_PTR_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    output logic             req,
    input  logic             gnt,
    output logic             beat,
    output logic             done,
    output logic             err_zero,
    output logic [PTR_W:0]   pending
);

    req_state_t       r_state;
    req_state_t       w_state_nxt;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] w_cnt_nxt;
    logic             r_req;
    logic             w_req_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err_zero;
    logic             w_beat;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [LEN_W-1:0] w_head;
    logic [PTR_W:0]   w_count;
    logic             w_zero_job;

    assign job_ready  = ~w_full;
    assign w_zero_job = job_valid & job_ready & (job_len == '0);
    assign w_push     = job_valid & job_ready & (job_len != '0);

    vlog_fsm_job_fifo #(
        .W     (LEN_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_job_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (job_len),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_req_nxt   = r_req;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        w_beat      = 1'b0;
        case (r_state)
            REQ_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_cnt_nxt   = w_head;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = REQ_ACTIVE;
                end
            end
            REQ_ACTIVE: begin
                // gnt low is a pause, not an abort: hold req and the count.
                if (r_req && gnt) begin
                    w_beat    = 1'b1;
                    w_cnt_nxt = r_cnt - LEN_W'(1);
                    if (r_cnt == LEN_W'(1)) begin
                        w_req_nxt   = 1'b0;
                        w_state_nxt = REQ_RELEASE;
                    end
                end
            end
            REQ_RELEASE: begin
                // The arbiter may keep gnt one cycle after req falls.
                if (!gnt) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = REQ_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = REQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= REQ_IDLE;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_done     <= 1'b0;
            r_err_zero <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_req      <= w_req_nxt;
            r_done     <= w_done_nxt;
            r_err_zero <= w_zero_job;
        end
    end

    assign req      = r_req;
    assign beat     = w_beat;
    assign done     = r_done;
    assign err_zero = r_err_zero;
    assign pending  = w_count;

endmodule : vlog_fsm_req_ctrl

// File: tb/tb_vlog_fsm_req_ctrl.sv
// tb/tb_vlog_fsm_req_ctrl.sv - directed self-checking bench for two request controllers and a grant arbiter
module tb_vlog_fsm_req_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       jv0, jv1, blk;
    logic [3:0] jl0, jl1;
    logic       jr0, jr1, req0, req1, beat0, beat1, done0, done1, ez0, ez1;
    logic [2:0] pend0, pend1;
    logic       r_g0, r_g1;
    logic       gnt0, gnt1;

    int checks = 0;
    int errors = 0;

    int beats0 = 0, beats1 = 0, dones0 = 0, dones1 = 0, ezs0 = 0;
    int rises0 = 0, gap_viol = 0, low0 = 100, run0 = 0;
    logic seen0 = 1'b0, prev_req0 = 1'b0;
    int pulses[$];

    always #5 clk = ~clk;

    assign gnt0 = r_g0 & ~blk;
    assign gnt1 = r_g1;

    // Registered two-requester arbiter, requester 0 has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g0 <= 1'b0;
            r_g1 <= 1'b0;
        end else if (r_g0) begin
            r_g0 <= req0;
        end else if (r_g1) begin
            r_g1 <= req1;
        end else if (req0) begin
            r_g0 <= 1'b1;
        end else if (req1) begin
            r_g1 <= 1'b1;
        end
    end

    vlog_fsm_req_ctrl u_dut0 (
        .clock(clk), .reset(rst), .job_valid(jv0), .job_len(jl0), .job_ready(jr0),
        .req(req0), .gnt(gnt0), .beat(beat0), .done(done0), .err_zero(ez0), .pending(pend0)
    );

    vlog_fsm_req_ctrl u_dut1 (
        .clock(clk), .reset(rst), .job_valid(jv1), .job_len(jl1), .job_ready(jr1),
        .req(req1), .gnt(gnt1), .beat(beat1), .done(done1), .err_zero(ez1), .pending(pend1)
    );

    always @(negedge clk) begin
        beats0 = beats0 + int'(beat0);
        beats1 = beats1 + int'(beat1);
        dones0 = dones0 + int'(done0);
        dones1 = dones1 + int'(done1);
        ezs0   = ezs0 + int'(ez0);
        if (req0 && !prev_req0) begin
            rises0 = rises0 + 1;
            if (seen0 && low0 < 2) gap_viol = gap_viol + 1;
            seen0 = 1'b1;
        end
        if (req0) begin
            run0 = run0 + 1;
            low0 = 0;
        end else begin
            if (prev_req0) begin
                pulses.push_back(run0);
                run0 = 0;
            end
            low0 = low0 + 1;
        end
        prev_req0 = req0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; jv0 = 1'b0; jv1 = 1'b0; jl0 = '0; jl1 = '0; blk = 1'b0;
        tick(); tick();
        checks++; if (req0 !== 1'b0)    begin errors++; $display("FAIL reset_req: got %b expected 0", req0); end
        checks++; if (done0 !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b expected 0", done0); end
        checks++; if (ez0 !== 1'b0 || ez1 !== 1'b0) begin errors++; $display("FAIL reset_err_zero: got %b%b expected 00", ez0, ez1); end
        checks++; if (pend0 !== 3'd0)   begin errors++; $display("FAIL reset_pending: got %0d expected 0", pend0); end
        checks++; if (jr0 !== 1'b1)     begin errors++; $display("FAIL reset_job_ready: got %b expected 1", jr0); end
        checks++; if (beat0 !== 1'b0)   begin errors++; $display("FAIL reset_beat: got %b expected 0", beat0); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int b, d, p, i;
        b = beats0; d = dones0; p = pulses.size();
        jl0 = 4'd3; jv0 = 1'b1;
        tick();
        jv0 = 1'b0;
        for (i = 0; i < 40 && dones0 == d; i++) tick();
        checks++; if (dones0 == d) begin errors++; $display("FAIL single_timeout: got no done expected done within 40 cycles"); end
        tick(); tick();
        checks++; if (beats0 - b !== 3) begin errors++; $display("FAIL single_beats: got %0d expected 3", beats0 - b); end
        checks++; if (dones0 - d !== 1) begin errors++; $display("FAIL single_done: got %0d expected 1", dones0 - d); end
        checks++; if (pulses.size() != p + 1 || pulses[p] != 4) begin
            errors++; $display("FAIL single_req_len: got %0d pulses expected one pulse of 4 cycles", pulses.size() - p);
        end
        checks++; if (pend0 !== 3'd0) begin errors++; $display("FAIL single_pending: got %0d expected 0", pend0); end
    endtask

    task automatic test_fill();
        int b, d, r, g, p, i;
        int exp_len[4];
        b = beats0; d = dones0; r = rises0; g = gap_viol; p = pulses.size();
        exp_len[0] = 2; exp_len[1] = 3; exp_len[2] = 2; exp_len[3] = 3;
        blk = 1'b1;
        // first len-1 job parks the FSM in ACTIVE, then 1,2,1,2 fill the FIFO
        jv0 = 1'b1;
        jl0 = 4'd1; tick();
        jl0 = 4'd1; tick();
        jl0 = 4'd2; tick();
        jl0 = 4'd1; tick();
        jl0 = 4'd2; tick();
        checks++; if (jr0 !== 1'b0)   begin errors++; $display("FAIL fill_job_ready: got %b expected 0", jr0); end
        checks++; if (pend0 !== 3'd4) begin errors++; $display("FAIL fill_pending: got %0d expected 4", pend0); end
        jl0 = 4'd3; tick();
        jv0 = 1'b0;
        checks++; if (pend0 !== 3'd4) begin errors++; $display("FAIL fill_ignored_push: got %0d expected 4", pend0); end
        checks++; if (ez0 !== 1'b0)   begin errors++; $display("FAIL fill_no_err: got %b expected 0", ez0); end
        blk = 1'b0;
        for (i = 0; i < 100 && dones0 - d < 5; i++) tick();
        tick(); tick();
        checks++; if (dones0 - d !== 5) begin errors++; $display("FAIL fill_dones: got %0d expected 5", dones0 - d); end
        checks++; if (beats0 - b !== 7) begin errors++; $display("FAIL fill_beats: got %0d expected 7", beats0 - b); end
        checks++; if (rises0 - r !== 5) begin errors++; $display("FAIL fill_req_rises: got %0d expected 5", rises0 - r); end
        checks++; if (gap_viol - g !== 0) begin errors++; $display("FAIL fill_gap: got %0d short gaps expected 0", gap_viol - g); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pulses.size() != p + 5 || pulses[p + 1 + k] != exp_len[k]) begin
                errors++; $display("FAIL fill_order_%0d: got pulse %0d expected %0d", k,
                                   (pulses.size() == p + 5) ? pulses[p + 1 + k] : -1, exp_len[k]);
            end
        end
        checks++; if (pend0 !== 3'd0 || jr0 !== 1'b1) begin errors++; $display("FAIL fill_drained: got pending %0d expected 0", pend0); end
    endtask

    task automatic test_pause();
        int b, d, i, bad, bp;
        b = beats0; d = dones0; bad = 0;
        jl0 = 4'd5; jv0 = 1'b1;
        tick();
        jv0 = 1'b0;
        for (i = 0; i < 30 && beats0 - b != 2; i++) tick();
        checks++; if (beats0 - b !== 2) begin errors++; $display("FAIL pause_reach: got %0d beats expected 2", beats0 - b); end
        blk = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (!req0 || beat0) bad++;
            tick();
        end
        bp = beats0 - b;
        blk = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL pause_hold: got %0d bad cycles expected 0", bad); end
        checks++; if (bp !== 2)  begin errors++; $display("FAIL pause_no_beat: got %0d beats expected 2", bp); end
        for (i = 0; i < 40 && dones0 == d; i++) tick();
        tick(); tick();
        checks++; if (beats0 - b !== 5) begin errors++; $display("FAIL pause_beats: got %0d expected 5", beats0 - b); end
        checks++; if (dones0 - d !== 1) begin errors++; $display("FAIL pause_done: got %0d expected 1", dones0 - d); end
    endtask

    task automatic test_zero();
        int e, r;
        e = ezs0; r = rises0;
        jl0 = 4'd0; jv0 = 1'b1;
        tick();
        jv0 = 1'b0;
        checks++; if (ez0 !== 1'b1) begin errors++; $display("FAIL zero_pulse: got %b expected 1", ez0); end
        tick();
        checks++; if (ez0 !== 1'b0) begin errors++; $display("FAIL zero_pulse_end: got %b expected 0", ez0); end
        checks++; if (pend0 !== 3'd0) begin errors++; $display("FAIL zero_pending: got %0d expected 0", pend0); end
        repeat (5) tick();
        checks++; if (rises0 - r !== 0) begin errors++; $display("FAIL zero_no_req: got %0d rises expected 0", rises0 - r); end
        checks++; if (ezs0 - e !== 1) begin errors++; $display("FAIL zero_count: got %0d expected 1", ezs0 - e); end
    endtask

    task automatic test_reset_mid();
        int d, r;
        blk = 1'b1;
        jv0 = 1'b1;
        jl0 = 4'd3; tick();
        jl0 = 4'd2; tick();
        tick();
        jv0 = 1'b0;
        tick();
        checks++; if (req0 !== 1'b1 || pend0 !== 3'd2) begin
            errors++; $display("FAIL rmid_setup: got req %b pending %0d expected req 1 pending 2", req0, pend0);
        end
        d = dones0; r = rises0;
        #2 rst = 1'b1;
        #1;
        checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL rmid_async_req: got %b expected 0", req0); end
        tick(); tick();
        rst = 1'b0;
        blk = 1'b0;
        repeat (10) tick();
        checks++; if (pend0 !== 3'd0) begin errors++; $display("FAIL rmid_pending: got %0d expected 0", pend0); end
        checks++; if (jr0 !== 1'b1)   begin errors++; $display("FAIL rmid_job_ready: got %b expected 1", jr0); end
        checks++; if (dones0 - d !== 0) begin errors++; $display("FAIL rmid_no_done: got %0d expected 0", dones0 - d); end
        checks++; if (rises0 - r !== 0 || req0 !== 1'b0) begin errors++; $display("FAIL rmid_no_req: got %0d rises expected 0", rises0 - r); end
    endtask

    task automatic test_two();
        int b0, b1, d0, d1, f0, f1, fall0, g1, ov;
        logic sr0;
        b0 = beats0; b1 = beats1; d0 = dones0; d1 = dones1;
        f0 = -1; f1 = -1; fall0 = -1; g1 = -1; ov = 0; sr0 = 1'b0;
        jl0 = 4'd2; jl1 = 4'd2; jv0 = 1'b1; jv1 = 1'b1;
        tick();
        jv0 = 1'b0; jv1 = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (beat0 && f0 < 0) f0 = c;
            if (beat1 && f1 < 0) f1 = c;
            if (req0) sr0 = 1'b1;
            if (!req0 && sr0 && fall0 < 0) fall0 = c;
            if (gnt1 && g1 < 0) g1 = c;
            if (beat0 && beat1) ov++;
            tick();
        end
        checks++; if (!(f0 >= 0 && f1 > f0)) begin errors++; $display("FAIL two_order: got first beats %0d/%0d expected req0 first", f0, f1); end
        checks++; if (!(fall0 >= 0 && g1 > fall0)) begin errors++; $display("FAIL two_gnt1_after: got gnt1 at %0d req0 fall %0d expected later", g1, fall0); end
        checks++; if (beats0 - b0 !== 2 || beats1 - b1 !== 2) begin errors++; $display("FAIL two_beats: got %0d/%0d expected 2/2", beats0 - b0, beats1 - b1); end
        checks++; if (dones0 - d0 !== 1 || dones1 - d1 !== 1) begin errors++; $display("FAIL two_dones: got %0d/%0d expected 1/1", dones0 - d0, dones1 - d1); end
        checks++; if (ov !== 0) begin errors++; $display("FAIL two_overlap: got %0d expected 0", ov); end
        checks++; if (pend1 !== 3'd0 || jr1 !== 1'b1 || req1 !== 1'b0) begin errors++; $display("FAIL two_idle1: got pending %0d expected 0", pend1); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_pause();
        test_zero();
        test_reset_mid();
        test_two();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_vlog_fsm_req_ctrl
